// File: rtl/ip_megarom_ascii8_pkg.sv
// Shared MSX cartridge bus constants: page bases, ROM window and the
// ASCII8 bank-register write window, plus the address-range helpers.
package ip_megarom_ascii8_pkg;

    localparam logic [15:0] PAGE0_BASE  = 16'h4000;
    localparam logic [15:0] PAGE1_BASE  = 16'h6000;
    localparam logic [15:0] PAGE2_BASE  = 16'h8000;
    localparam logic [15:0] PAGE3_BASE  = 16'hA000;

    localparam logic [15:0] ROM_LO      = PAGE0_BASE;
    localparam logic [15:0] ROM_HI      = 16'hBFFF;

    localparam logic [15:0] BANK_WIN_LO = 16'h6000;
    localparam logic [15:0] BANK_WIN_HI = 16'h7FFF;

    // True when a CPU address falls inside the banked ROM area.
    function automatic logic in_rom(input logic [15:0] a);
        return (a >= ROM_LO) && (a <= ROM_HI);
    endfunction

    // True when a CPU address falls inside the bank-register write window.
    function automatic logic in_bank_window(input logic [15:0] a);
        return (a >= BANK_WIN_LO) && (a <= BANK_WIN_HI);
    endfunction

endpackage

// File: rtl/ip_ascii8_bank_regs.sv
// ASCII8 bank register file and page decode. Four 8-bit bank registers,
// one per 8 KB page; the selected bank forms the upper address bits.
module ip_ascii8_bank_regs
    import ip_megarom_ascii8_pkg::*;
#(
    parameter logic [7:0] BANK_MASK = 8'hFF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [4:0]  addr_hi,
    input  logic [7:0]  data,
    output logic [20:0] page_addr
);

    logic [7:0] bank [4];
    logic [1:0] page;

    // Bank register update; addr[12:11] picks the register, mask sizes the ROM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= 8'h00;
            end
        end else if (wr) begin
            bank[addr_hi[1:0]] <= data & BANK_MASK;
        end
    end

    // Page decode from addr[15:13]; only pages 4000h-A000h ever reach a read
    always_comb begin
        page = 2'd3;
        case (addr_hi[4:2])
            PAGE0_BASE[15:13]: page = 2'd0;
            PAGE1_BASE[15:13]: page = 2'd1;
            PAGE2_BASE[15:13]: page = 2'd2;
            PAGE3_BASE[15:13]: page = 2'd3;
            default:           page = 2'd3;
        endcase
    end

    // Low 13 bits are supplied by the caller from the CPU address
    assign page_addr = {bank[page], 13'd0};

endmodule

// File: rtl/ip_megarom_ascii8.sv
// ASCII8 MegaROM mapper: accepts cartridge bus requests, updates bank
// registers on writes to 6000h-7FFFh and turns reads in 4000h-BFFFh into
// ROM memory requests with a banked 21-bit address.
module ip_megarom_ascii8
    import ip_megarom_ascii8_pkg::*;
#(
    parameter logic [7:0] BANK_MASK = 8'hFF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    input  logic        bus_memory_req,
    input  logic        bus_wrt,
    input  logic [7:0]  bus_wdata,
    output logic        bus_ack,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdata_en,
    output logic [20:0] mem_address,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rdata_en
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESPOND
    } state_t;

    state_t      state;
    logic [15:0] addr_q;
    logic        wrt_q;
    logic        accept;
    logic        bank_wr;
    logic [4:0]  bank_addr_hi;
    logic [20:0] page_addr;

    // A request is taken only from IDLE; elsewhere the upstream keeps it held
    assign accept = (state == ST_IDLE) && bus_memory_req;

    // The bank write happens on the accepting edge, so the new value is
    // already in place during the ACK cycle; this is where bus_wdata is kept.
    assign bank_wr = accept && bus_wrt && in_bank_window(bus_address);

    // Writes decode the live bus address, reads use the latched one
    assign bank_addr_hi = (state == ST_IDLE) ? bus_address[15:11] : addr_q[15:11];

    ip_ascii8_bank_regs #(
        .BANK_MASK (BANK_MASK)
    ) u_bank_regs (
        .clk       (clk),
        .reset     (reset),
        .wr        (bank_wr),
        .addr_hi   (bank_addr_hi),
        .data      (bus_wdata),
        .page_addr (page_addr)
    );

    // Capture the accepted request; data-only, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus_address;
            wrt_q  <= bus_wrt;
        end
    end

    // Handshake sequencer with registered bus and memory outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            bus_ack      <= 1'b0;
            bus_rdata_en <= 1'b0;
            bus_rdata    <= 8'h00;
            mem_req      <= 1'b0;
            mem_address  <= 21'd0;
        end else begin
            bus_ack      <= 1'b0;
            bus_rdata_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus_memory_req) begin
                        bus_ack <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // bus_memory_req is still high here and is deliberately ignored
                    if (!wrt_q && in_rom(addr_q)) begin
                        mem_req     <= 1'b1;
                        mem_address <= page_addr | {8'h00, addr_q[12:0]};
                        state       <= ST_MEM_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_rdata_en) begin
                            bus_rdata    <= mem_rdata;
                            bus_rdata_en <= 1'b1;
                            state        <= ST_RESPOND;
                        end else begin
                            state <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rdata_en) begin
                        bus_rdata    <= mem_rdata;
                        bus_rdata_en <= 1'b1;
                        state        <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
